// File: rtl/div_seq_ctrl_pkg.sv
// Shared definitions for the iterative-divide sequencer: the step count,
// the state encoding and the decision taken when a DIV request is accepted.
package div_seq_ctrl_pkg;

    localparam int DIV_STEPS = 32;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_RUN     = 3'd1;
    localparam state_t ST_CAPTURE = 3'd2;
    localparam state_t ST_DONE    = 3'd3;
    localparam state_t ST_EXC     = 3'd4;

    // A zero divisor never starts the divider; it goes straight to the exception.
    function automatic state_t start_target(input logic [31:0] divisor);
        return (divisor == 32'd0) ? ST_EXC : ST_RUN;
    endfunction

endpackage

// File: rtl/div_seq_ctrl.sv
// Sequencer for the iterative signed divider: latches operands, times the
// divider enable, captures quotient/remainder into LO/HI and serves MTHI/MTLO.
module div_seq_ctrl #(
    parameter int DIV_STEPS = div_seq_ctrl_pkg::DIV_STEPS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        hi_wr,
    input  logic        lo_wr,
    input  logic [31:0] wr_data,
    input  logic [31:0] div_lo_in,
    input  logic [31:0] div_hi_in,
    output logic        div_op,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    output logic        busy,
    output logic        done,
    output logic        div0_exc,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    import div_seq_ctrl_pkg::*;

    localparam logic [5:0] LAST_STEP = 6'(DIV_STEPS - 1);

    state_t     state;
    logic [5:0] cnt;
    logic       accept;

    // DONE counts as the exit point of an operation, so a waiting request is
    // taken on the same edge that releases busy and back-to-back DIVs lose no cycle.
    assign accept = start && ((state == ST_IDLE) || (state == ST_DONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
            div_a <= 32'd0;
            div_b <= 32'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        div_a <= op_a;
                        div_b <= op_b;
                        cnt   <= 6'd0;
                        state <= start_target(op_b);
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == LAST_STEP) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: state <= ST_DONE;
                ST_EXC:     state <= ST_IDLE;
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Results are copied bit-exact; moves from the register file only land while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (state == ST_CAPTURE) begin
            hi <= div_hi_in;
            lo <= div_lo_in;
        end else if (state == ST_IDLE) begin
            if (hi_wr) begin
                hi <= wr_data;
            end
            if (lo_wr) begin
                lo <= wr_data;
            end
        end
    end

    assign div_op   = (state == ST_RUN) || (state == ST_CAPTURE);
    assign busy     = (state != ST_IDLE);
    assign done     = (state == ST_DONE);
    assign div0_exc = (state == ST_EXC);

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a behavioural 32-step divider attached
// and a scoreboard of expected LO/HI results.
module tb_div_seq_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wr_data;
    logic [31:0] div_lo_in;
    logic [31:0] div_hi_in;
    logic        div_op;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        busy;
    logic        done;
    logic        div0_exc;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    div_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op_a      (op_a),
        .op_b      (op_b),
        .hi_wr     (hi_wr),
        .lo_wr     (lo_wr),
        .wr_data   (wr_data),
        .div_lo_in (div_lo_in),
        .div_hi_in (div_hi_in),
        .div_op    (div_op),
        .div_a     (div_a),
        .div_b     (div_b),
        .busy      (busy),
        .done      (done),
        .div0_exc  (div0_exc),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider stand-in: cleared while div_op is low, results appear after the 32nd enabled edge.
    logic [5:0]  step_cnt;
    logic [31:0] q_reg;
    logic [31:0] r_reg;
    always @(posedge clk) begin
        if (!div_op) begin
            step_cnt <= 6'd0;
            q_reg    <= 32'hDEADBEEF;
            r_reg    <= 32'hDEADBEEF;
        end else if (step_cnt < 6'd32) begin
            step_cnt <= step_cnt + 6'd1;
            if (step_cnt == 6'd31) begin
                q_reg <= $signed(div_a) / $signed(div_b);
                r_reg <= $signed(div_a) % $signed(div_b);
            end
        end
    end
    assign div_lo_in = q_reg;
    assign div_hi_in = r_reg;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic pushExp(input logic [31:0] elo, input logic [31:0] ehi);
        exp_t e;
        e.lo = elo;
        e.hi = ehi;
        sb.push_back(e);
    endtask

    task automatic popAndCompare(input string tag);
        exp_t e;
        checkOutput({tag, "_sb_depth"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput({tag, "_lo"}, lo, e.lo);
            checkOutput({tag, "_hi"}, hi, e.hi);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one DIV and follows it cycle by cycle; n counts edges after the start edge.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input int pulseAt, input int mtAt, input int resetAt,
                                 input logic [31:0] mtHiExp, input logic [31:0] mtLoExp,
                                 output int doneAt, output int busyCycles,
                                 output int divopCycles, output int excCycles);
        doneAt = -1;
        busyCycles = 0;
        divopCycles = 0;
        excCycles = 0;
        op_a = a;
        op_b = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        op_a = 32'hFFFF_FFFF;
        op_b = 32'hFFFF_FFFF;
        for (int n = 0; n < 60; n++) begin
            if (n > 0) tick();
            if (busy) busyCycles++;
            if (div_op) divopCycles++;
            if (div0_exc) excCycles++;
            if (done) begin
                doneAt = n;
                popAndCompare("result");
            end
            if (n == pulseAt) begin
                start = 1'b1;
                op_a = 32'd1;
                op_b = 32'd1;
            end
            if (n == pulseAt + 1) begin
                start = 1'b0;
                checkOutput("div_a_held", div_a, a);
                checkOutput("div_b_held", div_b, b);
            end
            if (n == mtAt) begin
                hi_wr = 1'b1;
                lo_wr = 1'b1;
                wr_data = 32'hFFFF_0000;
            end
            if (n == mtAt + 1) begin
                hi_wr = 1'b0;
                lo_wr = 1'b0;
                checkOutput("mt_in_run_hi", hi, mtHiExp);
                checkOutput("mt_in_run_lo", lo, mtLoExp);
            end
            if (n == resetAt) begin
                reset = 1'b1;
                #1;
                checkOutput("rst_run_div_op", 32'(div_op), 32'd0);
                checkOutput("rst_run_busy", 32'(busy), 32'd0);
                checkOutput("rst_run_done", 32'(done), 32'd0);
                checkOutput("rst_run_hi", hi, 32'd0);
                checkOutput("rst_run_lo", lo, 32'd0);
                #1;
                reset = 1'b0;
                break;
            end
            if (n > 0 && !busy) break;
        end
    endtask

    int doneAt, busyCycles, divopCycles, excCycles;
    int firstDone, secondDone;
    logic b2bBusyGap;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op_a = 32'd0;
        op_b = 32'd0;
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        wr_data = 32'd0;
        #3;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_div_op", 32'(div_op), 32'd0);
        checkOutput("rst_exc", 32'(div0_exc), 32'd0);
        checkOutput("rst_div_a", div_a, 32'd0);
        checkOutput("rst_div_b", div_b, 32'd0);
        checkOutput("rst_hi", hi, 32'd0);
        checkOutput("rst_lo", lo, 32'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] MTHI / MTLO in IDLE");
        hi_wr = 1'b1;
        wr_data = 32'h1234_5678;
        tick();
        hi_wr = 1'b0;
        checkOutput("mthi_hi", hi, 32'h1234_5678);
        checkOutput("mthi_lo", lo, 32'd0);
        lo_wr = 1'b1;
        wr_data = 32'h9ABC_DEF0;
        tick();
        lo_wr = 1'b0;
        checkOutput("mtlo_lo", lo, 32'h9ABC_DEF0);
        checkOutput("mtlo_hi", hi, 32'h1234_5678);

        $display("[TB] divide by zero");
        hi_wr = 1'b1;
        wr_data = 32'h0000_AAAA;
        tick();
        hi_wr = 1'b0;
        lo_wr = 1'b1;
        wr_data = 32'h0000_5555;
        tick();
        lo_wr = 1'b0;
        applyStimulus(32'd5, 32'd0, -5, -5, -5, 32'd0, 32'd0, doneAt, busyCycles, divopCycles, excCycles);
        checkOutput("div0_exc_cycles", 32'(excCycles), 32'd1);
        checkOutput("div0_busy_cycles", 32'(busyCycles), 32'd1);
        checkOutput("div0_div_op_cycles", 32'(divopCycles), 32'd0);
        checkOutput("div0_no_done", 32'(doneAt), 32'hFFFF_FFFF);
        checkOutput("div0_hi_kept", hi, 32'h0000_AAAA);
        checkOutput("div0_lo_kept", lo, 32'h0000_5555);

        $display("[TB] 100 / 7");
        pushExp(32'd14, 32'd2);
        applyStimulus(32'd100, 32'd7, -5, -5, -5, 32'd0, 32'd0, doneAt, busyCycles, divopCycles, excCycles);
        checkOutput("d100_done_at", 32'(doneAt), 32'd33);
        checkOutput("d100_busy_cycles", 32'(busyCycles), 32'd34);
        checkOutput("d100_div_op_cycles", 32'(divopCycles), 32'd33);
        checkOutput("d100_exc_cycles", 32'(excCycles), 32'd0);

        $display("[TB] 100 / 7 with stray start and MTHI/MTLO during RUN");
        pushExp(32'd14, 32'd2);
        applyStimulus(32'd100, 32'd7, 10, 5, -5, 32'd2, 32'd14, doneAt, busyCycles, divopCycles, excCycles);
        checkOutput("stray_done_at", 32'(doneAt), 32'd33);
        checkOutput("stray_busy_cycles", 32'(busyCycles), 32'd34);

        $display("[TB] reset during RUN");
        applyStimulus(32'd100, 32'd7, -5, -5, 12, 32'd0, 32'd0, doneAt, busyCycles, divopCycles, excCycles);
        checkOutput("rst_run_no_done", 32'(doneAt), 32'hFFFF_FFFF);
        checkOutput("rst_run_no_exc", 32'(excCycles), 32'd0);
        tick();
        checkOutput("rst_run_idle", 32'(busy), 32'd0);

        $display("[TB] 36 / 6 after reset");
        pushExp(32'd6, 32'd0);
        applyStimulus(32'd36, 32'd6, -5, -5, -5, 32'd0, 32'd0, doneAt, busyCycles, divopCycles, excCycles);
        checkOutput("d36_done_at", 32'(doneAt), 32'd33);

        $display("[TB] -100 / 7 signed");
        pushExp(32'hFFFF_FFF2, 32'hFFFF_FFFE);
        applyStimulus(32'hFFFF_FF9C, 32'd7, -5, -5, -5, 32'd0, 32'd0, doneAt, busyCycles, divopCycles, excCycles);
        checkOutput("neg_done_at", 32'(doneAt), 32'd33);

        $display("[TB] back-to-back 81 / 9");
        pushExp(32'd9, 32'd0);
        pushExp(32'd9, 32'd0);
        firstDone = -1;
        secondDone = -1;
        b2bBusyGap = 1'b0;
        op_a = 32'd81;
        op_b = 32'd9;
        start = 1'b1;
        tick();
        for (int n = 0; n < 100; n++) begin
            if (n > 0) tick();
            if (!busy && firstDone >= 0 && secondDone < 0) b2bBusyGap = 1'b1;
            if (done) begin
                popAndCompare("b2b");
                if (firstDone < 0) firstDone = n;
                else secondDone = n;
            end
            if (firstDone >= 0 && n == firstDone + 1) start = 1'b0;
            if (secondDone >= 0 && !busy) break;
        end
        start = 1'b0;
        checkOutput("b2b_first_done", 32'(firstDone), 32'd33);
        checkOutput("b2b_spacing", 32'(secondDone - firstDone), 32'd34);
        checkOutput("b2b_busy_gap", 32'(b2bBusyGap), 32'd0);
        checkOutput("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
